// File: rtl/imem_loader_if.sv
// Byte stream in from the UART receiver and word writes out to the instruction RAM.
// A byte transfers on a rising clk edge where rx_valid and rx_ready are both 1; the source holds rx_data stable while rx_valid is 1 and unaccepted.
interface imem_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: length-prefixed little-endian byte stream -> word writes, CPU held in reset until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum word after the data words.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  imem_loader_if.slave     bus,
  output logic             cpu_hold,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_loaded,
  output logic [2:0]       state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN    = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK    = 3'd3;
  localparam logic [2:0] S_AFTER  = S_CHK;
`else
  localparam logic [2:0] S_AFTER  = S_FINISH;
`endif

  logic [2:0]       state;
  logic [1:0]       byte_idx;
  logic [23:0]      part;
  logic [CNT_W-1:0] len_q;
  logic [31:0]      word;
  logic             accept;
  logic             last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      chk_acc;
`endif

  // The 4th byte is never stored; it is merged combinationally on its acceptance cycle.
  assign word      = {bus.rx_data, part};
  assign accept    = bus.rx_valid & bus.rx_ready;
  assign last_byte = accept & (byte_idx == 2'd3);
  assign state_dbg = state;

  always_comb begin
    bus.rx_ready = 1'b0;
    if (state == S_LEN || state == S_DATA) bus.rx_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (state == S_CHK) bus.rx_ready = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      byte_idx       <= 2'd0;
      part           <= '0;
      len_q          <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      cpu_hold       <= 1'b1;
      done           <= 1'b0;
      err            <= 1'b0;
      words_loaded   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_acc        <= '0;
`endif
    end else begin
      bus.imem_we <= 1'b0;
      if (accept && byte_idx != 2'd3) part[{byte_idx, 3'b000} +: 8] <= bus.rx_data;
      if (accept) byte_idx <= byte_idx + 2'd1;

      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_LEN;
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= '0;
            cpu_hold     <= 1'b1;
            byte_idx     <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc      <= '0;
`endif
          end
        end
        S_LEN: begin
          if (last_byte) begin
            if (word > 32'(DEPTH)) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end else if (word == 32'd0) begin
              state <= S_AFTER;
            end else begin
              len_q <= word[CNT_W-1:0];
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (last_byte) begin
            // Counter and strobe become visible on the same cycle; the address uses the pre-increment count.
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= {{(30-CNT_W){1'b0}}, words_loaded, 2'b00};
            bus.imem_wdata <= word;
            words_loaded   <= words_loaded + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_acc        <= chk_acc ^ word;
`endif
            if (words_loaded + CNT_W'(1) == len_q) state <= S_AFTER;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (last_byte) begin
            if (word == chk_acc) begin
              state <= S_FINISH;
            end else begin
              err   <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
`endif
        S_FINISH: begin
          done     <= 1'b1;
          cpu_hold <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
